// File: rtl/t03_mem_pkg.sv
// Shared types and size codes for the memory request controller and its lane aligner.
package t03_mem_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    DATA_RD,
    DATA_WR,
    FAULT
  } mem_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/t03_lane_align.sv
// Byte-lane logic: select generation, store replication and load extract/extend.
// Purely combinational so the MMIO decoder can share it.
module t03_lane_align
  import t03_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_a,
  input  logic        i_unsigned,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_raw,
  output logic [3:0]  o_sel,
  output logic        o_misaligned,
  output logic [31:0] o_store_rep,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_load_raw >> {i_a, 3'b000};

  always_comb begin
    o_sel        = 4'b0000;
    o_misaligned = 1'b0;
    o_store_rep  = i_store_data;
    o_load_data  = w_shifted;
    case (i_size)
      SIZE_BYTE: begin
        o_sel       = 4'b0001 << i_a;
        o_store_rep = {4{i_store_data[7:0]}};
        o_load_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      end
      SIZE_HALF: begin
        o_misaligned = i_a[0];
        o_sel        = i_a[0] ? 4'b0000 : (4'b0011 << i_a);
        o_store_rep  = {2{i_store_data[15:0]}};
        o_load_data  = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      end
      SIZE_WORD: begin
        o_misaligned = (i_a != 2'b00);
        o_sel        = (i_a != 2'b00) ? 4'b0000 : 4'b1111;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/t03_mem_request_ctrl.sv
// Sequences instruction fetch and data load/store over one shared bus port,
// holding request signals stable until ack and trapping misalignment/timeouts.
module t03_mem_request_ctrl
  import t03_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        size,
  input  logic              loadUnsigned,
  input  logic [ADDR_W-1:0] pcMemory,
  input  logic [ADDR_W-1:0] resultALU,
  input  logic [31:0]       storeData,
  input  logic [31:0]       busDataIn,
  input  logic              ack,
  output logic              read,
  output logic              write,
  output logic [3:0]        sel,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       busDataOut,
  output logic [31:0]       instr,
  output logic [31:0]       loadData,
  output logic              freezePC,
  output logic              freezeInstr,
  output logic              fault
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic [31:0]       r_instr;
  logic [31:0]       r_load;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_store;
  logic [3:0]        r_sel;
  logic [CNT_W-1:0]  r_wait;

  logic              w_in_exec;
  logic              w_mem_op;
  logic [1:0]        w_al_size;
  logic [1:0]        w_al_a;
  logic              w_al_unsigned;
  logic [31:0]       w_al_store;
  logic [3:0]        w_al_sel;
  logic              w_misaligned;
  logic [31:0]       w_store_rep;
  logic [31:0]       w_load_data;
  logic              w_timeout;
  logic              w_read;
  logic              w_write;
  logic [3:0]        w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic              w_freeze_pc;
  logic              w_freeze_instr;
  logic              w_wait_phase;

  assign w_in_exec = (r_state == EXEC);
  assign w_mem_op  = memRead | memWrite;

  // The aligner sees live operands while deciding in EXEC, latched ones during the data phase.
  assign w_al_size     = w_in_exec ? size              : r_size;
  assign w_al_a        = w_in_exec ? resultALU[1:0]    : r_addr[1:0];
  assign w_al_unsigned = w_in_exec ? loadUnsigned      : r_unsigned;
  assign w_al_store    = w_in_exec ? storeData         : r_store;

  t03_lane_align u_align (
    .i_size       (w_al_size),
    .i_a          (w_al_a),
    .i_unsigned   (w_al_unsigned),
    .i_store_data (w_al_store),
    .i_load_raw   (busDataIn),
    .o_sel        (w_al_sel),
    .o_misaligned (w_misaligned),
    .o_store_rep  (w_store_rep),
    .o_load_data  (w_load_data)
  );

  assign w_timeout = (TIMEOUT_CYC != 0) && (r_wait == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_next         = r_state;
    w_read         = 1'b0;
    w_write        = 1'b0;
    w_sel          = 4'b0000;
    w_addr         = r_addr;
    w_freeze_pc    = 1'b1;
    w_freeze_instr = 1'b1;
    w_wait_phase   = 1'b0;
    case (r_state)
      FETCH: begin
        w_read       = 1'b1;
        w_addr       = pcMemory;
        w_sel        = 4'b1111;
        w_wait_phase = 1'b1;
        if (ack)            w_next = EXEC;
        else if (w_timeout) w_next = FAULT;
      end
      EXEC: begin
        w_freeze_instr = 1'b0;
        if (w_mem_op) begin
          if (w_misaligned) w_next = FAULT;
          else if (memRead) w_next = DATA_RD;
          else              w_next = DATA_WR;
        end else begin
          w_freeze_pc = 1'b0;
          w_next      = FETCH;
        end
      end
      DATA_RD, DATA_WR: begin
        w_read       = (r_state == DATA_RD);
        w_write      = (r_state == DATA_WR);
        w_sel        = r_sel;
        w_wait_phase = 1'b1;
        if (ack) begin
          w_freeze_pc = 1'b0;
          w_next      = FETCH;
        end else if (w_timeout) begin
          w_next = FAULT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= FETCH;
      r_instr    <= '0;
      r_load     <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_store    <= '0;
      r_sel      <= '0;
      r_wait     <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)         r_wait <= '0;
      else if (w_wait_phase && !ack) r_wait <= r_wait + CNT_W'(1);
      if (r_state == FETCH && ack)   r_instr <= busDataIn;
      if (r_state == DATA_RD && ack) r_load  <= w_load_data;
      if (w_in_exec && w_mem_op) begin
        r_addr     <= resultALU;
        r_size     <= size;
        r_unsigned <= loadUnsigned;
        r_store    <= storeData;
        r_sel      <= w_al_sel;
      end
    end
  end

  // Requests are gated by reset so they drop the instant nrst falls.
  assign read        = w_read & nrst;
  assign write       = w_write & nrst;
  assign sel         = w_sel;
  assign address     = w_addr;
  assign busDataOut  = w_store_rep;
  assign instr       = r_instr;
  assign loadData    = r_load;
  assign freezePC    = w_freeze_pc;
  assign freezeInstr = w_freeze_instr;
  assign fault       = (r_state == FAULT);

endmodule

// File: doc/t03_mem_request_ctrl.md
# t03_mem_request_ctrl

Parametrised memory request controller between the single-cycle core and the wishbone manager / MMIO. It sequences instruction fetch and data load/store over one shared bus port and holds stable address, data and byte-select until `ack`. It also aligns and extends load data and flags misaligned accesses and bus timeouts. It drives the PC and instruction-register freeze controls.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `TIMEOUT_CYC`, 255: maximum wait cycles for `ack`; 0 disables the timeout.

Ports:
- `clk` input 1: clock. Everything is rising-edge.
- `nrst` input 1: asynchronous, active-low reset.
- `memRead` input 1: current instruction is a load.
- `memWrite` input 1: current instruction is a store.
- `size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `loadUnsigned` input 1: zero-extend load data (1) or sign-extend it (0).
- `pcMemory` input ADDR_W: fetch address.
- `resultALU` input ADDR_W: data address.
- `storeData` input 32: store value, LSB-aligned.
- `busDataIn` input 32: bus read data.
- `ack` input 1: bus transfer complete.
- `read` output 1: bus read request.
- `write` output 1: bus write request.
- `sel` output 4: byte lane enables.
- `address` output ADDR_W: bus address.
- `busDataOut` output 32: lane-replicated store data.
- `instr` output 32: registered instruction.
- `loadData` output 32: registered, aligned, extended load result.
- `freezePC` output 1: 0 for exactly one cycle per retired instruction.
- `freezeInstr` output 1: 1 while `instr` is not valid.
- `fault` output 1: sticky misalignment/timeout error.

## Operation
- States: FETCH, EXEC, DATA_RD, DATA_WR, FAULT.
- Reset values:
  - State is FETCH.
  - `instr`, `loadData`, `fault` and the wait counter are 0.
  - Registered address/data/sel are 0.
- FETCH:
  - Outputs: `read`=1, `address`=`pcMemory`, `sel`=1111, `freezePC`=1, `freezeInstr`=1.
  - On `ack`: `instr`←`busDataIn`, go to EXEC.
- EXEC:
  - `freezeInstr`=0, `read`=`write`=0.
  - `memRead` → DATA_RD. `memRead` has priority when `memRead` and `memWrite` are both 1.
  - Else `memWrite` → DATA_WR.
  - Else `freezePC`=0 this cycle → FETCH.
  - On entry to DATA_RD or DATA_WR, the following are latched and held constant until exit: `resultALU`, `size`, `loadUnsigned`, `storeData`, computed `sel`.
  - A misaligned or illegal `size` → FAULT; no bus request is issued.
- Alignment rule, with a = `resultALU[1:0]`:
  - Byte: `sel` = 0001<<a.
  - Half: requires a[0]=0; `sel` = 0011<<a.
  - Word: requires a=00; `sel` = 1111.
- `address` in DATA_RD/DATA_WR is the latched address with bits [1:0] passed unchanged.
- `busDataOut` is byte replicated ×4 for byte, half replicated ×2 for half, `storeData` for word.
- DATA_RD:
  - `read`=1, `freezeInstr`=1.
  - On `ack`: `loadData` ← `busDataIn` shifted right by 8·a, masked to size and extended; `freezePC`=0 that cycle; → FETCH.
- DATA_WR:
  - `write`=1, `freezeInstr`=1.
  - On `ack`: `freezePC`=0 → FETCH.
- Timeout:
  - The wait counter clears on every state change and counts while in FETCH, DATA_RD or DATA_WR with `ack`=0.
  - Reaching `TIMEOUT_CYC` → FAULT.
- FAULT:
  - `fault`=1; `read`, `write`, `sel` are 0; `freezePC`=`freezeInstr`=1.
  - Exits only via `nrst`.
- `ack` outside FETCH, DATA_RD and DATA_WR is ignored.

## Timing
- The next state is registered. Outputs are combinational from state plus latched registers. `freezePC` in EXEC also depends on `memRead`/`memWrite`.
- Non-memory instruction: fetch wait + 1 EXEC cycle. Load/store: fetch wait + 1 + data wait.
- `ack` in the same cycle a request is first asserted is legal. The transfer completes that cycle, giving a minimum of 1 cycle per bus phase.
- `instr` and `loadData` update on the clock edge that samples `ack`. Both are valid the following cycle.
- Request signals never change while awaiting `ack`.
- An `nrst` assertion mid-transfer drops `read`/`write` immediately (asynchronously) and returns the block to FETCH.
- With `TIMEOUT_CYC`=N, FAULT is entered on the Nth consecutive non-`ack` cycle of a phase.

## Structure
- Package `t03_mem_pkg`:
  - State enum `mem_state_t`.
  - Size codes `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
- Sub-module `t03_lane_align`: combinational `sel`/store replication/load extract-and-extend from size, a and unsigned. It is reused by the MMIO decoder.

## Test plan
- Reset, then a NOP at `pcMemory`=0x100 with `ack` after 2 cycles → `instr` loaded; `freezePC` low for exactly one cycle; a second fetch starts immediately.
- Byte load at 0x2003, `busDataIn`=0x80FF_FFFF, `loadUnsigned`=0 → `sel`=1000, `loadData`=0xFFFF_FF80; with `loadUnsigned`=1 → 0x0000_0080.
- Half store at 0x2002, `storeData`=0x0000_BEEF → `sel`=1100, `busDataOut`=0xBEEF_BEEF, `write` held until `ack`.
- Word load at 0x2001 → FAULT, no `read`/`write` asserted, `fault`=1 until `nrst`.
- `memRead`=`memWrite`=1 → read performed. Separately, `ack` withheld with `TIMEOUT_CYC`=4 → `fault` rises on the 4th wait cycle.
- `nrst` asserted mid DATA_WR → `write` drops without a clock edge; after release, FETCH at the current `pcMemory`.
